// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch front end.
package instr_fetch_unit_pkg;

  localparam int WORD_SIZE      = 19;
  localparam int ADDR_WIDTH     = 12;
  localparam logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int TIMER_WIDTH    = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_DELIVER
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Program-memory request/ack bus plus the valid/ready link to the instruction register.
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  logic                  memReq;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic                  memAck;
  logic [WORD_SIZE-1:0]  memRdata;
  logic [WORD_SIZE-1:0]  instrOut;
  logic                  instrValid;
  logic                  instrReady;

  // Fetch unit side
  modport master (
    output memReq, memAddr, instrOut, instrValid,
    input  memAck, memRdata, instrReady
  );

  // Memory and instruction-register side
  modport slave (
    input  memReq, memAddr, instrOut, instrValid,
    output memAck, memRdata, instrReady
  );

endinterface

// File: rtl/instr_fetch_unit_pc_counter.sv
// Program counter: reset to RESET_VECTOR, load a branch target, or step by one
// (wrapping modulo 2**ADDR_WIDTH). Load takes priority over increment.
module pc_counter
  import instr_fetch_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  inc_i,
  input  logic [ADDR_WIDTH-1:0] target_i,
  output logic [ADDR_WIDTH-1:0] pcNext_o,
  output logic [ADDR_WIDTH-1:0] pc_o
);

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_d;

  // Select the next PC: branch target first, then sequential step, else hold
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = target_i;
    end else if (inc_i) begin
      pc_d = pc_q + 1'b1;
    end
  end

  // PC register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pcNext_o = pc_d;
  assign pc_o     = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: IDLE -> REQ (wait for memory ack) -> DELIVER (wait for
// instruction register). Branches redirect the PC; a branch during an outstanding
// request marks the returning word for discard.
// Optional feature: define FETCH_TIMEOUT_EN to add the memory-ack watchdog and the
// sticky fetchErr_o flag; without it a request waits indefinitely.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  halt_i,
  input  logic                  branchTaken_i,
  input  logic [ADDR_WIDTH-1:0] branchTarget_i,
  instr_fetch_unit_if.master    bus,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  fetchErr_o
);

  fetch_state_t          state_q, state_d;
  logic                  discard_q, discard_d;
  logic [WORD_SIZE-1:0]  instrOut_q, instrOut_d;
  logic                  instrValid_q, instrValid_d;
  logic [ADDR_WIDTH-1:0] reqAddr_q, reqAddr_d;
  logic                  pcLoad, pcInc;
  logic [ADDR_WIDTH-1:0] pcNext;
  logic                  timeoutHit;

  pc_counter uPcCounter (
    .clk      (clk),
    .rst      (rst),
    .load_i   (pcLoad),
    .inc_i    (pcInc),
    .target_i (branchTarget_i),
    .pcNext_o (pcNext),
    .pc_o     (pc_o)
  );

`ifdef FETCH_TIMEOUT_EN
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic                   fetchErr_q, fetchErr_d;

  assign timeoutHit = (state_q == FETCH_REQ) && !bus.memAck &&
                      (timer_q == TIMER_WIDTH'(TIMEOUT_CYCLES - 1));

  // Watchdog counts cycles spent in the current request; error is sticky until reset
  always_comb begin
    timer_d    = '0;
    fetchErr_d = fetchErr_q | timeoutHit;
    if ((state_q == FETCH_REQ) && (state_d == FETCH_REQ) && !bus.memAck) begin
      timer_d = timer_q + 1'b1;
    end
  end

  // Watchdog registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q    <= '0;
      fetchErr_q <= 1'b0;
    end else begin
      timer_q    <= timer_d;
      fetchErr_q <= fetchErr_d;
    end
  end

  assign fetchErr_o = fetchErr_q;
`else
  assign timeoutHit = 1'b0;
  assign fetchErr_o = 1'b0;
`endif

  // Next-state, PC control and delivered-word logic
  always_comb begin
    state_d      = state_q;
    discard_d    = discard_q;
    instrOut_d   = instrOut_q;
    instrValid_d = instrValid_q;
    pcLoad       = 1'b0;
    pcInc        = 1'b0;
    case (state_q)
      FETCH_IDLE: begin
        pcLoad = branchTaken_i;
        if (start_i && !halt_i) begin
          state_d = FETCH_REQ;
        end
      end
      FETCH_REQ: begin
        if (timeoutHit) begin
          pcLoad    = branchTaken_i;
          discard_d = 1'b0;
          state_d   = FETCH_IDLE;
        end else if (bus.memAck) begin
          discard_d = 1'b0;
          if (branchTaken_i || discard_q) begin
            pcLoad  = branchTaken_i;
            state_d = halt_i ? FETCH_IDLE : FETCH_REQ;
          end else begin
            instrOut_d   = bus.memRdata;
            instrValid_d = 1'b1;
            pcInc        = 1'b1;
            state_d      = FETCH_DELIVER;
          end
        end else if (branchTaken_i) begin
          pcLoad    = 1'b1;
          discard_d = 1'b1;
        end
      end
      FETCH_DELIVER: begin
        pcLoad = branchTaken_i;
        if (bus.instrReady || branchTaken_i) begin
          instrValid_d = 1'b0;
          state_d      = halt_i ? FETCH_IDLE : FETCH_REQ;
        end
      end
      default: begin
        state_d = FETCH_IDLE;
      end
    endcase
  end

  // Capture the request address whenever a fresh request starts so it stays stable
  always_comb begin
    reqAddr_d = reqAddr_q;
    if ((state_d == FETCH_REQ) && ((state_q != FETCH_REQ) || bus.memAck)) begin
      reqAddr_d = pcNext;
    end
  end

  // FSM and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH_IDLE;
      discard_q    <= 1'b0;
      instrOut_q   <= '0;
      instrValid_q <= 1'b0;
      reqAddr_q    <= '0;
    end else begin
      state_q      <= state_d;
      discard_q    <= discard_d;
      instrOut_q   <= instrOut_d;
      instrValid_q <= instrValid_d;
      reqAddr_q    <= reqAddr_d;
    end
  end

  assign bus.memReq     = (state_q == FETCH_REQ);
  assign bus.memAddr    = reqAddr_q;
  assign bus.instrOut   = instrOut_q;
  assign bus.instrValid = instrValid_q;

endmodule
